// File: rtl/perf_pkg.sv
// perf_pkg
//   Shared types and defaults for the run controller / performance monitor.
//   - run_state_e : run controller state encoding (IDLE, RUN, DONE, TIMEOUT)
//   - CNT_W_DEF   : default width of the cycle/instruction/stall counters
//   - XLEN_DEF    : default width of PC and watched value
//   - cnt_is_max  : helper, true when a counter value sits at its all-ones ceiling
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } run_state_e;

    localparam int unsigned CNT_W_DEF = 32;
    localparam int unsigned XLEN_DEF  = 32;

    // True when every bit of a (up to 64-bit) counter of width w is set.
    function automatic logic cnt_is_max(input logic [63:0] val, input int unsigned w);
        logic [63:0] ones;
        ones = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        return (val & ones) == ones;
    endfunction

endpackage

// File: rtl/perf_counter.sv
// perf_counter
//   Saturating up-counter used for the cycle, instruction and stall counts.
//   A clear wins over an increment; once the count reaches all-ones it holds.
// Ports
//   clk_i   in  1  clock
//   rst_ni  in  1  asynchronous active-low reset (count -> 0)
//   clr_i   in  1  synchronous clear to 0
//   inc_i   in  1  increment by one unless saturated
//   cnt_o   out W  current count
module perf_counter
    import perf_pkg::*;
#(
    parameter int unsigned W = CNT_W_DEF
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_max;

    assign at_max = (cnt_q == {W{1'b1}});

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !at_max) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/perf_run_ctrl.sv
// perf_run_ctrl
//   Run controller and performance monitor placed beside the RV32I core.
//   start_i arms a run: counters clear and the current PC is captured. While
//   in RUN every cycle is counted, a PC change counts as a retired
//   instruction, and the run ends when watch_i equals target_i (DONE), when
//   the cycle budget is used up (TIMEOUT) or on abort_i (IDLE). Counts freeze
//   outside RUN until the next start.
//
//   Optional feature macro: PERF_STALL_CNT_EN
//     defined   : stall_cnt_o counts RUN cycles with an unchanged PC
//     undefined : no stall counter is built, stall_cnt_o is tied to 0
//
// Ports
//   clk_i        in  1      core clock
//   rst_ni       in  1      asynchronous active-low reset
//   start_i      in  1      pulse: clear counters, begin run (ignored in RUN)
//   abort_i      in  1      pulse: leave RUN for IDLE, counts kept
//   pc_i         in  XLEN   current fetch PC
//   watch_i      in  XLEN   watched architectural value
//   target_i     in  XLEN   value of watch_i that ends the run
//   running_o    out 1      high in RUN
//   done_o       out 1      high in DONE
//   timeout_o    out 1      high in TIMEOUT
//   cycle_cnt_o  out CNT_W  cycles spent in RUN
//   instr_cnt_o  out CNT_W  PC changes observed in RUN
//   stall_cnt_o  out CNT_W  RUN cycles with unchanged PC (0 when not built)
//
// Handshake note: start_i and abort_i are single-cycle level samples taken
// at the rising edge; there is no ready/ack. abort_i beats every other RUN
// exit, and start_i is only honoured outside RUN.
module perf_run_ctrl
    import perf_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned MAX_CYCLES = 1_000_000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  watch_i,
    input  logic [XLEN-1:0]  target_i,
    output logic             running_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instr_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    run_state_e      state_q;
    logic [XLEN-1:0] pc_q;

    logic in_run;
    logic start_ok;
    logic pc_moved;
    logic match;
    logic budget_hit;

    assign in_run   = (state_q == RUN);
    assign start_ok = start_i && !in_run;
    assign pc_moved = (pc_i != pc_q);
    assign match    = (watch_i == target_i);

    // The cycle being counted now is number cycle_cnt+1, so the budget is
    // exhausted when the registered count already equals MAX_CYCLES-1.
    // Compared at 64 bits so a narrow counter never aliases a large budget.
    assign budget_hit = (64'(cycle_cnt_o) == (64'(MAX_CYCLES) - 64'd1));

    // Run state machine; pc_q is reloaded at start and on every RUN cycle so
    // the first RUN cycle compares against the PC seen on the start edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    pc_q <= pc_i;
                    if (abort_i) begin
                        state_q <= IDLE;
                    end else if (match) begin
                        state_q <= DONE;
                    end else if (budget_hit) begin
                        state_q <= TIMEOUT;
                    end
                end
                IDLE, DONE, TIMEOUT: begin
                    if (start_i) begin
                        state_q <= RUN;
                        pc_q    <= pc_i;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Status outputs decode straight from the state register.
    assign running_o = (state_q == RUN);
    assign done_o    = (state_q == DONE);
    assign timeout_o = (state_q == TIMEOUT);

    perf_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (start_ok),
        .inc_i  (in_run),
        .cnt_o  (cycle_cnt_o)
    );

    perf_counter #(.W(CNT_W)) u_instr_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (start_ok),
        .inc_i  (in_run && pc_moved),
        .cnt_o  (instr_cnt_o)
    );

`ifdef PERF_STALL_CNT_EN
    perf_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (start_ok),
        .inc_i  (in_run && !pc_moved),
        .cnt_o  (stall_cnt_o)
    );
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_perf_run_ctrl.sv
// tb_perf_run_ctrl
//   Bench for perf_run_ctrl. Main instance uses a 16-cycle budget; a second
//   instance with 4-bit counters and the default budget covers saturation.
//   Build with or without PERF_STALL_CNT_EN; stall expectations follow.
module tb_perf_run_ctrl;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned MAX_C = 16;
    localparam int unsigned SAT_W = 4;

    typedef logic [3*1+3*32-1:0] exp_t;

    typedef struct {
        int period;     // PC advances by 4 every 'period' RUN cycles
        int match_cyc;  // RUN cycle on which watch equals target (0 = never)
        int abort_cyc;  // RUN cycle on which abort_i is high (0 = never)
        int len;        // RUN-relative cycles driven after start
        bit e_run;
        bit e_done;
        bit e_to;
        int e_cyc;
        int e_ins;
        int e_stl;
    } vec_t;

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic abort;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] watch;
    logic [XLEN-1:0] target;

    logic             running, done, timeout;
    logic [CNT_W-1:0] cycle_cnt, instr_cnt, stall_cnt;
    logic             s_running, s_done, s_timeout;
    logic [SAT_W-1:0] s_cycle_cnt, s_instr_cnt, s_stall_cnt;

    always #5 clk = ~clk;

    perf_run_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W), .MAX_CYCLES(MAX_C)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .pc_i        (pc),
        .watch_i     (watch),
        .target_i    (target),
        .running_o   (running),
        .done_o      (done),
        .timeout_o   (timeout),
        .cycle_cnt_o (cycle_cnt),
        .instr_cnt_o (instr_cnt),
        .stall_cnt_o (stall_cnt)
    );

    perf_run_ctrl #(.XLEN(XLEN), .CNT_W(SAT_W)) dut_sat (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .pc_i        (pc),
        .watch_i     (watch),
        .target_i    (target),
        .running_o   (s_running),
        .done_o      (s_done),
        .timeout_o   (s_timeout),
        .cycle_cnt_o (s_cycle_cnt),
        .instr_cnt_o (s_instr_cnt),
        .stall_cnt_o (s_stall_cnt)
    );

    // ---------------- scoreboard ----------------
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    function automatic logic [31:0] stl(input int v);
`ifdef PERF_STALL_CNT_EN
        return 32'(v);
`else
        if (v < 0) return 32'd1;
        return 32'd0;
`endif
    endfunction

    task automatic expect_out(input bit r, input bit d, input bit t,
                              input int c, input int i, input logic [31:0] s);
        exp_q.push_back({r, d, t, 32'(c), 32'(i), s});
    endtask

    task automatic check_out(input string name, input bit sat);
        exp_t e;
        exp_t a;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard queue empty", name);
            return;
        end
        e = exp_q.pop_front();
        if (sat)
            a = {s_running, s_done, s_timeout, 28'd0, s_cycle_cnt,
                 28'd0, s_instr_cnt, 28'd0, s_stall_cnt};
        else
            a = {running, done, timeout, cycle_cnt, instr_cnt, stall_cnt};
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got run=%0b done=%0b to=%0b cyc=%0d ins=%0d stl=%0d want run=%0b done=%0b to=%0b cyc=%0d ins=%0d stl=%0d",
                     name, a[98], a[97], a[96], a[95:64], a[63:32], a[31:0],
                     e[98], e[97], e[96], e[95:64], e[63:32], e[31:0]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [XLEN-1:0] base, input string name);
        pc    = base;
        start = 1'b1;
        abort = 1'b0;
        tick();
        start = 1'b0;
        expect_out(1, 0, 0, 0, 0, 32'd0);
        check_out(name, 1'b0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [XLEN-1:0] base;
        base   = $urandom;
        base   = {base[XLEN-1:2], 2'b00};
        target = 32'hCAFE_0000 + 32'(idx);
        watch  = ~target;
        do_start(base, $sformatf("vec%0d_start_clear", idx));
        for (int c = 1; c <= v.len; c++) begin
            pc    = base + 32'(4 * (c / v.period));
            watch = (c == v.match_cyc) ? target : ~target;
            abort = (c == v.abort_cyc);
            tick();
        end
        abort = 1'b0;
        watch = ~target;
        expect_out(v.e_run, v.e_done, v.e_to, v.e_cyc, v.e_ins, stl(v.e_stl));
        check_out($sformatf("vec%0d_final", idx), 1'b0);
    endtask

    vec_t vecs[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [XLEN-1:0] base;

        // per, match, abort, len, run, done, to, cyc, ins, stl
        vecs[0] = '{1, 10, 0, 12, 0, 1, 0, 10, 10, 0}; // step +4, match at 10
        vecs[1] = '{3,  9, 0,  9, 0, 1, 0,  9,  3, 6}; // stalls 2 of 3
        vecs[2] = '{1,  0, 0, 18, 0, 0, 1, 16, 16, 0}; // budget expires
        vecs[3] = '{1, 16, 0, 16, 0, 1, 0, 16, 16, 0}; // match on budget cycle
        vecs[4] = '{2,  0, 5,  7, 0, 0, 0,  5,  2, 3}; // abort at 5, frozen after
        vecs[5] = '{1,  4, 4,  4, 0, 0, 0,  4,  4, 0}; // abort beats match
        vecs[6] = '{1,  1, 0,  3, 0, 1, 0,  1,  1, 0}; // match on first cycle

        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        pc     = '0;
        watch  = '0;
        target = '0;
        repeat (2) @(posedge clk);
        #1;
        expect_out(0, 0, 0, 0, 0, 32'd0);
        check_out("reset_values", 1'b0);
        rst_n = 1'b1;
        tick();
        // watch == target here, but IDLE must not react to it
        expect_out(0, 0, 0, 0, 0, 32'd0);
        check_out("idle_ignores_match", 1'b0);

        for (int k = 0; k < 7; k++) begin
            run_vec(vecs[k], k);
        end

        // Budget boundary: still running after 15 cycles, TIMEOUT on the 16th.
        base   = 32'h0000_1000;
        target = 32'h1234_5678;
        watch  = ~target;
        do_start(base, "tmo_start");
        for (int c = 1; c <= 15; c++) begin
            pc = base + 32'(4 * c);
            tick();
        end
        expect_out(1, 0, 0, 15, 15, 32'd0);
        check_out("tmo_cycle15_running", 1'b0);
        pc = base + 32'(4 * 16);
        tick();
        expect_out(0, 0, 1, 16, 16, 32'd0);
        check_out("tmo_cycle16_timeout", 1'b0);

        // start_i inside RUN is ignored; start_i+abort_i together aborts.
        base = 32'h0000_2000;
        do_start(base, "restart_start");
        for (int c = 1; c <= 3; c++) begin
            pc = base + 32'(4 * c);
            tick();
        end
        pc    = base + 32'd16;
        start = 1'b1;
        tick();
        expect_out(1, 0, 0, 4, 4, 32'd0);
        check_out("start_ignored_in_run", 1'b0);
        pc    = base + 32'd20;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        expect_out(0, 0, 0, 5, 5, 32'd0);
        check_out("start_abort_together", 1'b0);
        repeat (2) begin
            pc = pc + 32'd4;
            tick();
        end
        expect_out(0, 0, 0, 5, 5, 32'd0);
        check_out("idle_counts_frozen", 1'b0);

        // Asynchronous reset mid-run at cycle 7, away from any clock edge.
        base = 32'h0000_3000;
        do_start(base, "arst_start");
        for (int c = 1; c <= 7; c++) begin
            pc = base + 32'(4 * c);
            tick();
        end
        expect_out(1, 0, 0, 7, 7, 32'd0);
        check_out("arst_before", 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out(0, 0, 0, 0, 0, 32'd0);
        check_out("arst_immediate", 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        expect_out(0, 0, 0, 0, 0, 32'd0);
        check_out("arst_after_release", 1'b0);

        // Saturation on the 4-bit instance: 20 RUN cycles, counts stop at 15.
        base   = 32'h0000_4000;
        target = 32'h0BAD_0BAD;
        watch  = ~target;
        pc     = base;
        start  = 1'b1;
        tick();
        start = 1'b0;
        expect_out(1, 0, 0, 0, 0, 32'd0);
        check_out("sat_start", 1'b1);
        for (int c = 1; c <= 20; c++) begin
            pc = base + 32'(4 * c);
            tick();
        end
        expect_out(1, 0, 0, 15, 15, 32'd0);
        check_out("sat_counts_hold", 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        expect_out(0, 0, 0, 15, 15, 32'd0);
        check_out("sat_abort", 1'b1);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
